// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and wait-counter sizing.
package data_mem_responder_pkg;

    localparam int MR_MAX_WAIT_STATES = 15;
    localparam int MR_WAIT_CNT_W      = $clog2(MR_MAX_WAIT_STATES + 1);

    typedef enum logic [1:0] {
        MR_IDLE    = 2'd0,
        MR_ACCESS  = 2'd1,
        MR_RESPOND = 2'd2
    } mem_resp_state_t;

    function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned depth);
        return (addr >= depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU memory-access state (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, busy
    );
endinterface

// File: rtl/data_mem_responder_sp_ram.sv
// Single-port storage array: synchronous write, combinational read, no reset on contents.
module sp_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES hold cycles, one-cycle response pulse.
// Optional MEM_RESP_FAULT_EN: array shrinks to MEM_DEPTH words and higher addresses fault.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 2,
    parameter int MEM_DEPTH   = 192
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_responder_if.slave bus
);
`ifdef MEM_RESP_FAULT_EN
    localparam int RAM_DEPTH = MEM_DEPTH;
`else
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
`endif
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    if (WAIT_STATES < 0 || WAIT_STATES > MR_MAX_WAIT_STATES ||
        MEM_DEPTH < 1 || MEM_DEPTH > 2 ** ADDR_WIDTH) begin : g_cfg_check
        $error("data_mem_responder: illegal WAIT_STATES or MEM_DEPTH");
    end

    mem_resp_state_t          state_q, state_d;
    logic [MR_WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                     wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
    logic                     resp_error_q, resp_error_d;
    logic                     fault_s;
    logic                     ram_we_s;
    logic [DATA_WIDTH-1:0]    ram_rdata_s;

`ifdef MEM_RESP_FAULT_EN
    assign fault_s = addr_out_of_range(32'(addr_q), MEM_DEPTH);
`else
    assign fault_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter, request latch and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q   <= {MR_WAIT_CNT_W{1'b0}};
            wr_q         <= 1'b0;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            wdata_q      <= {DATA_WIDTH{1'b0}};
            resp_rdata_q <= {DATA_WIDTH{1'b0}};
            resp_error_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    // Next-state, latch and commit decisions
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        ram_we_s     = 1'b0;
        case (state_q)
            MR_IDLE: begin
                if (bus.req_valid) begin
                    state_d    = MR_ACCESS;
                    wait_cnt_d = MR_WAIT_CNT_W'(WAIT_STATES);
                    wr_d       = bus.req_write;
                    addr_d     = bus.req_addr;
                    wdata_d    = bus.req_wdata;
                end else begin
                    state_d = MR_IDLE;
                end
            end
            MR_ACCESS: begin
                if (|wait_cnt_q) begin
                    wait_cnt_d = wait_cnt_q - MR_WAIT_CNT_W'(1'b1);
                end else begin
                    state_d      = MR_RESPOND;
                    // Reset on the commit edge must still leave the array untouched
                    ram_we_s     = wr_q & ~fault_s & ~reset;
                    resp_error_d = fault_s;
                    if (wr_q) begin
                        resp_rdata_d = wdata_q;
                    end else if (fault_s) begin
                        resp_rdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        resp_rdata_d = ram_rdata_s;
                    end
                end
            end
            MR_RESPOND: begin
                state_d = MR_IDLE;
            end
            default: begin
                state_d = MR_IDLE;
            end
        endcase
    end

    // Status outputs decoded from state only
    always_comb begin
        bus.req_ready  = (state_q == MR_IDLE);
        bus.busy       = (state_q != MR_IDLE);
        bus.resp_valid = (state_q == MR_RESPOND);
    end

    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_error = resp_error_q;

    sp_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (addr_q[RAM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata_s)
    );
endmodule
